wb_grf: RTL and testbench

- Write-back stage plus general register file. Sits directly downstream of the MEM/WB pipeline register and consumes its W-stage outputs.
- Selects and load-extends the write-back data, then writes the 32x32 GPR array.
- Serves the two D-stage read ports, with same-cycle write-through bypass.
- Exports the final write-back value for forwarding and keeps a retired-instruction counter.

---
 rtl/wb_grf.sv | 134 +++++++++++++
 tb/tb_wb_grf.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
//==============================================================================
// Module      : wb_grf
// Description : Write-back stage and 32x32 general register file. Selects and
//               load-extends the write-back data, writes the GPR array, serves
//               two read ports with same-cycle write-through bypass, exports
//               the final write-back value and counts retired instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_grf #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] PC8_W,
    input  logic [31:0] D_W,
    input  logic [31:0] C_W,
    input  logic [4:0]  A3_W,
    input  logic        RegWrite_W,
    input  logic [1:0]  WDSel_W,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [31:0] WD_W,
    output logic [31:0] retire_cnt,
    output logic [31:0] trace_pc
);

    // Load opcodes that need sub-word extraction
    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LH  = 6'b100001;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_LBU = 6'b100100;
    localparam logic [5:0] c_OP_LHU = 6'b100101;

    // Write-data select encodings; 2'd3 is reserved and falls back to ALU
    localparam logic [1:0] c_SEL_ALU  = 2'd0;
    localparam logic [1:0] c_SEL_MEM  = 2'd1;
    localparam logic [1:0] c_SEL_LINK = 2'd2;

    logic [5:0]  w_opcode;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wd;
    logic        w_we;
    logic        w_unused;

    logic [31:0] r_grf [NREG];
    logic [31:0] r_retire_cnt;
    logic [31:0] r_trace_pc;

    assign w_opcode = instr_W[31:26];
    // Only the opcode field of the instruction matters here
    assign w_unused = ^instr_W[25:0];

    // Byte lane picked by the address offset; halfword ignores C_W[0]
    always_comb begin
        w_byte = D_W[7:0];
        case (C_W[1:0])
            2'd0:    w_byte = D_W[7:0];
            2'd1:    w_byte = D_W[15:8];
            2'd2:    w_byte = D_W[23:16];
            default: w_byte = D_W[31:24];
        endcase
        w_half = C_W[1] ? D_W[31:16] : D_W[15:0];
    end

    // Load extension keyed on opcode; unknown opcodes pass the raw word
    always_comb begin
        w_load_data = D_W;
        case (w_opcode)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'h0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'h0, w_half};
            c_OP_LW:  w_load_data = D_W;
            default:  w_load_data = D_W;
        endcase
    end

    // Final write-back data mux, independent of RegWrite_W
    always_comb begin
        w_wd = C_W;
        case (WDSel_W)
            c_SEL_ALU:  w_wd = C_W;
            c_SEL_MEM:  w_wd = w_load_data;
            c_SEL_LINK: w_wd = PC8_W;
            default:    w_wd = C_W;
        endcase
    end

    // Writes to $0 are dropped so entry 0 stays zero forever
    assign w_we = RegWrite_W && (A3_W != 5'd0);

    // Register array, trace PC and retire counter; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= '0;
            end
            r_retire_cnt <= '0;
            r_trace_pc   <= RESET_PC;
        end else begin
            if (w_we) begin
                r_grf[A3_W] <= w_wd;
                r_trace_pc  <= PC_W;
            end
            if (instr_W != 32'h0) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    // Read ports: $0 is hard zero, then same-cycle bypass, then array
    assign RD1_D = (A1_D == 5'd0)                     ? 32'h0 :
                   (RegWrite_W && (A3_W == A1_D))     ? w_wd  :
                                                        r_grf[A1_D];
    assign RD2_D = (A2_D == 5'd0)                     ? 32'h0 :
                   (RegWrite_W && (A3_W == A2_D))     ? w_wd  :
                                                        r_grf[A2_D];

    assign WD_W       = w_wd;
    assign retire_cnt = r_retire_cnt;
    assign trace_pc   = r_trace_pc;

endmodule

`default_nettype wire

// File: tb/tb_wb_grf.sv
//==============================================================================
// Module      : tb_wb_grf
// Description : Directed self-checking bench for wb_grf.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] instr_W;
    logic [31:0] PC_W;
    logic [31:0] PC8_W;
    logic [31:0] D_W;
    logic [31:0] C_W;
    logic [4:0]  A3_W;
    logic        RegWrite_W;
    logic [1:0]  WDSel_W;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [31:0] WD_W;
    logic [31:0] retire_cnt;
    logic [31:0] trace_pc;

    int checks;
    int errors;
    logic [31:0] exp_trace;

    localparam logic [31:0] c_I_LB  = {6'b100000, 26'h0};
    localparam logic [31:0] c_I_LBU = {6'b100100, 26'h0};
    localparam logic [31:0] c_I_LH  = {6'b100001, 26'h0};
    localparam logic [31:0] c_I_LHU = {6'b100101, 26'h0};
    localparam logic [31:0] c_I_LW  = {6'b100011, 26'h0};
    localparam logic [31:0] c_I_ADD = 32'h00A5_2020;
    localparam logic [31:0] c_I_ADI = {6'b001000, 26'h0};

    wb_grf #(
        .NREG     (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_W    (instr_W),
        .PC_W       (PC_W),
        .PC8_W      (PC8_W),
        .D_W        (D_W),
        .C_W        (C_W),
        .A3_W       (A3_W),
        .RegWrite_W (RegWrite_W),
        .WDSel_W    (WDSel_W),
        .A1_D       (A1_D),
        .A2_D       (A2_D),
        .RD1_D      (RD1_D),
        .RD2_D      (RD2_D),
        .WD_W       (WD_W),
        .retire_cnt (retire_cnt),
        .trace_pc   (trace_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_W    = 32'h0;
        PC_W       = 32'h0;
        PC8_W      = 32'h0;
        D_W        = 32'h0;
        C_W        = 32'h0;
        A3_W       = 5'd0;
        RegWrite_W = 1'b0;
        WDSel_W    = 2'd0;
        A1_D       = 5'd0;
        A2_D       = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_retire_cnt got %h exp %h", retire_cnt, 32'h0);
        end
        checks++;
        if (trace_pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_trace_pc got %h exp %h", trace_pc, 32'h0000_3000);
        end
        exp_trace = 32'h0000_3000;
        for (int i = 0; i < 32; i++) begin
            A1_D = 5'(i);
            A2_D = 5'(31 - i);
            #1;
            checks++;
            if (RD1_D !== 32'h0 || RD2_D !== 32'h0) begin
                errors++;
                $display("FAIL reset_read idx %0d got rd1=%h rd2=%h exp 0", i, RD1_D, RD2_D);
            end
        end
    endtask

    task automatic test_alu_write();
        instr_W    = c_I_ADD;
        PC_W       = 32'h0000_3010;
        RegWrite_W = 1'b1;
        WDSel_W    = 2'd0;
        A3_W       = 5'd5;
        C_W        = 32'h1234_5678;
        A1_D       = 5'd5;
        A2_D       = 5'd6;
        #1;
        checks++;
        if (RD1_D !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_bypass got %h exp %h", RD1_D, 32'h1234_5678);
        end
        checks++;
        if (WD_W !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_wd got %h exp %h", WD_W, 32'h1234_5678);
        end
        checks++;
        if (RD2_D !== 32'h0) begin
            errors++;
            $display("FAIL alu_other_port got %h exp %h", RD2_D, 32'h0);
        end
        step();
        exp_trace  = 32'h0000_3010;
        RegWrite_W = 1'b0;
        instr_W    = 32'h0;
        C_W        = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (RD1_D !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_stored got %h exp %h", RD1_D, 32'h1234_5678);
        end
        checks++;
        if (trace_pc !== exp_trace) begin
            errors++;
            $display("FAIL alu_trace_pc got %h exp %h", trace_pc, exp_trace);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] instr_tab [9];
        logic [31:0] off_tab   [9];
        logic [31:0] exp_tab   [9];
        instr_tab = '{c_I_LB,       c_I_LBU,      c_I_LH,       c_I_LHU,
                      c_I_LW,       c_I_ADI,      c_I_LH,       c_I_LB,
                      c_I_LHU};
        off_tab   = '{32'h3,        32'h2,        32'h2,        32'h0,
                      32'h1,        32'h2,        32'h3,        32'h1,
                      32'h1};
        exp_tab   = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01,
                      32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h0000007F,
                      32'h00007F01};
        RegWrite_W = 1'b0;
        WDSel_W    = 2'd1;
        D_W        = 32'h80FF_7F01;
        for (int i = 0; i < 9; i++) begin
            instr_W = instr_tab[i];
            C_W     = off_tab[i];
            #1;
            checks++;
            if (WD_W !== exp_tab[i]) begin
                errors++;
                $display("FAIL load_ext vec %0d got %h exp %h", i, WD_W, exp_tab[i]);
            end
        end
        // Reserved select behaves as the ALU path
        WDSel_W = 2'd3;
        C_W     = 32'h0BAD_F00D;
        #1;
        checks++;
        if (WD_W !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wdsel_reserved got %h exp %h", WD_W, 32'h0BAD_F00D);
        end
        // Commit a sign-extended byte load into $9
        WDSel_W    = 2'd1;
        instr_W    = c_I_LB;
        C_W        = 32'h0000_1003;
        PC_W       = 32'h0000_3020;
        A3_W       = 5'd9;
        RegWrite_W = 1'b1;
        step();
        exp_trace  = 32'h0000_3020;
        RegWrite_W = 1'b0;
        instr_W    = 32'h0;
        A2_D       = 5'd9;
        #1;
        checks++;
        if (RD2_D !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL load_stored got %h exp %h", RD2_D, 32'hFFFF_FF80);
        end
    endtask

    task automatic test_zero_reg();
        instr_W    = c_I_ADD;
        RegWrite_W = 1'b1;
        A3_W       = 5'd0;
        WDSel_W    = 2'd2;
        PC8_W      = 32'h0000_3008;
        PC_W       = 32'h0000_3000;
        A1_D       = 5'd0;
        A2_D       = 5'd5;
        #1;
        checks++;
        if (RD1_D !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass got %h exp %h", RD1_D, 32'h0);
        end
        checks++;
        if (WD_W !== 32'h0000_3008) begin
            errors++;
            $display("FAIL zero_wd got %h exp %h", WD_W, 32'h0000_3008);
        end
        step();
        RegWrite_W = 1'b0;
        instr_W    = 32'h0;
        #1;
        checks++;
        if (RD1_D !== 32'h0) begin
            errors++;
            $display("FAIL zero_stored got %h exp %h", RD1_D, 32'h0);
        end
        checks++;
        if (trace_pc !== exp_trace) begin
            errors++;
            $display("FAIL zero_trace_pc got %h exp %h", trace_pc, exp_trace);
        end
        checks++;
        if (RD2_D !== 32'h1234_5678) begin
            errors++;
            $display("FAIL zero_r5_intact got %h exp %h", RD2_D, 32'h1234_5678);
        end
    endtask

    task automatic test_back_to_back();
        A1_D       = 5'd12;
        A2_D       = 5'd12;
        A3_W       = 5'd12;
        WDSel_W    = 2'd2;
        PC8_W      = 32'hCAFE_0008;
        RegWrite_W = 1'b0;
        #1;
        checks++;
        if (RD1_D !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_when_idle got %h exp %h", RD1_D, 32'h0);
        end
        RegWrite_W = 1'b1;
        instr_W    = c_I_ADD;
        PC_W       = 32'h0000_3040;
        #1;
        checks++;
        if (RD1_D !== 32'hCAFE_0008 || RD2_D !== 32'hCAFE_0008) begin
            errors++;
            $display("FAIL dual_bypass got rd1=%h rd2=%h exp %h", RD1_D, RD2_D, 32'hCAFE_0008);
        end
        step();
        exp_trace = 32'h0000_3040;
        // Second write to the same register straight after the first
        WDSel_W = 2'd0;
        C_W     = 32'h5555_AAAA;
        PC_W    = 32'h0000_3044;
        #1;
        checks++;
        if (RD2_D !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL b2b_bypass got %h exp %h", RD2_D, 32'h5555_AAAA);
        end
        step();
        exp_trace  = 32'h0000_3044;
        RegWrite_W = 1'b0;
        instr_W    = 32'h0;
        #1;
        checks++;
        if (RD1_D !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL b2b_stored got %h exp %h", RD1_D, 32'h5555_AAAA);
        end
        checks++;
        if (trace_pc !== exp_trace) begin
            errors++;
            $display("FAIL b2b_trace_pc got %h exp %h", trace_pc, exp_trace);
        end
    endtask

    task automatic test_counter_reset();
        logic [31:0] seq [4];
        seq = '{32'h2002_0001, 32'h0000_0000, 32'h0000_0001, 32'h8C01_0004};
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_W = seq[i];
            step();
            if (i == 0) begin
                checks++;
                if (retire_cnt !== 32'd1) begin
                    errors++;
                    $display("FAIL cnt_first got %0d exp %0d", retire_cnt, 1);
                end
            end
        end
        instr_W = 32'h0;
        #1;
        checks++;
        if (retire_cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_total got %0d exp %0d", retire_cnt, 3);
        end
        // Put a known value in $7 so the reset has something to clear
        RegWrite_W = 1'b1;
        WDSel_W    = 2'd0;
        A3_W       = 5'd7;
        C_W        = 32'h0000_0077;
        PC_W       = 32'h0000_3100;
        step();
        RegWrite_W = 1'b0;
        A1_D       = 5'd7;
        #1;
        checks++;
        if (RD1_D !== 32'h0000_0077) begin
            errors++;
            $display("FAIL pre_reset_r7 got %h exp %h", RD1_D, 32'h0000_0077);
        end
        // Reset coincides with a write and a live instruction
        reset      = 1'b1;
        RegWrite_W = 1'b1;
        C_W        = 32'h0000_0055;
        instr_W    = c_I_ADD;
        PC_W       = 32'h0000_3104;
        step();
        reset      = 1'b0;
        RegWrite_W = 1'b0;
        instr_W    = 32'h0;
        #1;
        checks++;
        if (RD1_D !== 32'h0) begin
            errors++;
            $display("FAIL reset_prio_r7 got %h exp %h", RD1_D, 32'h0);
        end
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_prio_cnt got %0d exp %0d", retire_cnt, 0);
        end
        checks++;
        if (trace_pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_prio_trace got %h exp %h", trace_pc, 32'h0000_3000);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_ext();
        test_zero_reg();
        test_back_to_back();
        test_counter_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
